// File: rtl/pmu_voltage_sequencer_if.sv
// ============================================================================
// Module      : pmu_voltage_sequencer_if
// Description : DVFS <-> PMU voltage handshake and status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pmu_voltage_sequencer_if;
    logic        voltage_request;
    logic [7:0]  voltage_target;
    logic        clr_err;
    logic        voltage_stable;
    logic [7:0]  vout_code;
    logic        ramp_active;
    logic        ramp_dir_up;
    logic        err_clamped;
    logic [15:0] transaction_count;

    // DVFS controller side
    modport master (
        output voltage_request, voltage_target, clr_err,
        input  voltage_stable, vout_code, ramp_active, ramp_dir_up,
               err_clamped, transaction_count
    );

    // PMU sequencer side
    modport slave (
        input  voltage_request, voltage_target, clr_err,
        output voltage_stable, vout_code, ramp_active, ramp_dir_up,
               err_clamped, transaction_count
    );
endinterface

`default_nettype wire

// File: rtl/pmu_voltage_sequencer.sv
// ============================================================================
// Module      : pmu_voltage_sequencer
// Description : Slews the regulator trim code toward a DVFS target, settles,
//               then reports voltage_stable. Optional: PMU_POWER_GOOD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmu_voltage_sequencer #(
    parameter int unsigned STEP_SIZE     = 2,
    parameter int unsigned STEP_CYCLES   = 100,
    parameter int unsigned SETTLE_CYCLES = 200,
    parameter int unsigned VMIN_CODE     = 40,
    parameter int unsigned VMAX_CODE     = 110,
    parameter int unsigned RESET_CODE    = 100
`ifdef PMU_POWER_GOOD_EN
    ,
    parameter int unsigned PGOOD_MIN_CODE = 55
`endif
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    pmu_voltage_sequencer_if.slave      bus
`ifdef PMU_POWER_GOOD_EN
    ,
    output logic                        power_good
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_STABLE = 2'd3
    } state_t;

    localparam int unsigned STEP_W   = (STEP_CYCLES   > 1) ? $clog2(STEP_CYCLES)   : 1;
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [STEP_W-1:0]   C_STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] C_SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]          C_VMIN        = 8'(VMIN_CODE);
    localparam logic [7:0]          C_VMAX        = 8'(VMAX_CODE);
    localparam logic [7:0]          C_RESET       = 8'(RESET_CODE);
    localparam logic [8:0]          C_STEP        = 9'(STEP_SIZE);

    state_t              state_q, state_d;
    logic [7:0]          vout_q, vout_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                dir_up_q, dir_up_d;
    logic                stable_q;
    logic                ramp_active_q;
    logic                err_q;
    logic [15:0]         count_q;

    logic [7:0]          eff_target;
    logic                out_of_range;
    logic signed [8:0]   diff;
    logic [8:0]          mag;
    logic [7:0]          step_amt;
    logic [7:0]          vout_stepped;

    always_comb begin
        eff_target   = bus.voltage_target;
        out_of_range = 1'b0;
        if (bus.voltage_target < C_VMIN) begin
            eff_target   = C_VMIN;
            out_of_range = 1'b1;
        end else if (bus.voltage_target > C_VMAX) begin
            eff_target   = C_VMAX;
            out_of_range = 1'b1;
        end
    end

    // Step is limited to the remaining distance so the ramp lands exactly on target.
    assign diff         = signed'({1'b0, eff_target}) - signed'({1'b0, vout_q});
    assign mag          = diff[8] ? 9'(-diff) : 9'(diff);
    assign step_amt     = (mag > C_STEP) ? C_STEP[7:0] : mag[7:0];
    assign vout_stepped = diff[8] ? (vout_q - step_amt) : (vout_q + step_amt);

    always_comb begin
        state_d      = state_q;
        vout_d       = vout_q;
        step_cnt_d   = step_cnt_q;
        settle_cnt_d = settle_cnt_q;
        dir_up_d     = dir_up_q;

        if (!bus.voltage_request) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_SETTLE, ST_STABLE: begin
                    if (eff_target != vout_q) begin
                        state_d    = ST_RAMP;
                        step_cnt_d = '0;
                        dir_up_d   = ~diff[8];
                    end else if (state_q == ST_IDLE) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                    end else if (state_q == ST_SETTLE) begin
                        if (settle_cnt_q == C_SETTLE_LAST) begin
                            state_d = ST_STABLE;
                        end else begin
                            settle_cnt_d = settle_cnt_q + 1'b1;
                        end
                    end
                end
                ST_RAMP: begin
                    if (eff_target == vout_q) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                    end else if (step_cnt_q == C_STEP_LAST) begin
                        // Final step goes straight to SETTLE so RAMP spans whole step periods only.
                        vout_d     = vout_stepped;
                        step_cnt_d = '0;
                        dir_up_d   = ~diff[8];
                        if (vout_stepped == eff_target) begin
                            state_d      = ST_SETTLE;
                            settle_cnt_d = '0;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vout_q        <= C_RESET;
            step_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            dir_up_q      <= 1'b0;
            stable_q      <= 1'b0;
            ramp_active_q <= 1'b0;
            err_q         <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            vout_q        <= vout_d;
            step_cnt_q    <= step_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            dir_up_q      <= dir_up_d;
            stable_q      <= (state_d == ST_STABLE);
            ramp_active_q <= (state_d == ST_RAMP) || (state_d == ST_SETTLE);
            if (bus.voltage_request && out_of_range) begin
                err_q <= 1'b1;
            end else if (bus.clr_err) begin
                err_q <= 1'b0;
            end
            if ((state_d == ST_STABLE) && (state_q != ST_STABLE)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.voltage_stable    = stable_q;
    assign bus.vout_code         = vout_q;
    assign bus.ramp_active       = ramp_active_q;
    assign bus.ramp_dir_up       = dir_up_q;
    assign bus.err_clamped       = err_q;
    assign bus.transaction_count = count_q;

`ifdef PMU_POWER_GOOD_EN
    localparam logic [7:0] C_PGOOD_MIN = 8'(PGOOD_MIN_CODE);

    logic pgood_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pgood_q <= 1'b0;
        end else begin
            pgood_q <= (vout_d >= C_PGOOD_MIN) && (state_d != ST_RAMP);
        end
    end

    assign power_good = pgood_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pmu_voltage_sequencer.sv
// ============================================================================
// Module      : tb_pmu_voltage_sequencer
// Description : Directed, table-driven bench for pmu_voltage_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmu_voltage_sequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
`ifdef PMU_POWER_GOOD_EN
    logic power_good;
`endif

    pmu_voltage_sequencer_if vif ();

    pmu_voltage_sequencer #(
        .STEP_SIZE    (2),
        .STEP_CYCLES  (4),
        .SETTLE_CYCLES(8),
        .VMIN_CODE    (40),
        .VMAX_CODE    (110),
        .RESET_CODE   (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (vif.slave)
`ifdef PMU_POWER_GOOD_EN
        ,
        .power_good(power_good)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  target;
        logic [7:0]  exp_vout;
        int          exp_lat;
        logic        exp_dir;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_stable(output int n);
        n = 0;
        while (!vif.voltage_stable && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_vout(input logic [7:0] code);
        int n;
        n = 0;
        while (vif.vout_code != code && n < 400) begin
            tick();
            n++;
        end
        check("reach_vout", 32'(vif.vout_code), 32'(code));
    endtask

    task automatic drop_request();
        vif.voltage_request = 1'b0;
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vout"},   32'(vif.vout_code), 32'd100);
        check({tag, "_stable"}, 32'(vif.voltage_stable), 32'd0);
        check({tag, "_active"}, 32'(vif.ramp_active), 32'd0);
        check({tag, "_dir"},    32'(vif.ramp_dir_up), 32'd0);
        check({tag, "_err"},    32'(vif.err_clamped), 32'd0);
        check({tag, "_cnt"},    32'(vif.transaction_count), 32'd0);
`ifdef PMU_POWER_GOOD_EN
        check({tag, "_pgood"},  32'(power_good), 32'd0);
`endif
    endtask

    initial begin
        int lat;
        n_cmp = 0;
        n_bad = 0;

        //         target exp_vout lat dir err cnt
        vecs[0] = '{8'd60,  8'd60,  89,  1'b0, 1'b0, 16'd1};
        vecs[1] = '{8'd100, 8'd100, 89,  1'b1, 1'b0, 16'd2};
        vecs[2] = '{8'd20,  8'd40,  129, 1'b0, 1'b1, 16'd3};
        vecs[3] = '{8'd60,  8'd60,  49,  1'b1, 1'b0, 16'd4};
        vecs[4] = '{8'd61,  8'd61,  13,  1'b1, 1'b0, 16'd5};
        vecs[5] = '{8'd61,  8'd61,  9,   1'b1, 1'b0, 16'd6};
        vecs[6] = '{8'd200, 8'd110, 109, 1'b1, 1'b1, 16'd7};

        rst_n               = 1'b0;
        vif.voltage_request = 1'b0;
        vif.voltage_target  = 8'd0;
        vif.clr_err         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;
        tick();
        check("post_rst_vout", 32'(vif.vout_code), 32'd100);

        for (int i = 0; i < 7; i++) begin
            vif.voltage_target  = vecs[i].target;
            vif.voltage_request = 1'b1;
            tick();
            check($sformatf("v%0d_active", i), 32'(vif.ramp_active), 32'd1);
            check($sformatf("v%0d_no_stale", i), 32'(vif.voltage_stable), 32'd0);
            wait_stable(lat);
            lat = lat + 1;
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_vout", i), 32'(vif.vout_code), 32'(vecs[i].exp_vout));
            check($sformatf("v%0d_dir", i), 32'(vif.ramp_dir_up), 32'(vecs[i].exp_dir));
            check($sformatf("v%0d_err", i), 32'(vif.err_clamped), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_cnt", i), 32'(vif.transaction_count), 32'(vecs[i].exp_cnt));
            drop_request();
            check($sformatf("v%0d_drop_stable", i), 32'(vif.voltage_stable), 32'd0);
            check($sformatf("v%0d_drop_active", i), 32'(vif.ramp_active), 32'd0);
            check($sformatf("v%0d_hold_vout", i), 32'(vif.vout_code), 32'(vecs[i].exp_vout));
            vif.clr_err = 1'b1;
            tick();
            vif.clr_err = 1'b0;
            check($sformatf("v%0d_clr_err", i), 32'(vif.err_clamped), 32'd0);
        end

        // Retarget while STABLE: stable drops on the same edge that re-enters RAMP.
        vif.voltage_target  = 8'd110;
        vif.voltage_request = 1'b1;
        tick();
        wait_stable(lat);
        check("stab_lat", 32'(lat + 1), 32'd9);
        vif.voltage_target = 8'd104;
        tick();
        check("retgt_stable_drop", 32'(vif.voltage_stable), 32'd0);
        check("retgt_active", 32'(vif.ramp_active), 32'd1);
        wait_stable(lat);
        check("retgt_lat", 32'(lat + 1), 32'd21);
        check("retgt_vout", 32'(vif.vout_code), 32'd104);
        check("retgt_dir", 32'(vif.ramp_dir_up), 32'd0);
        check("retgt_cnt", 32'(vif.transaction_count), 32'd9);
        drop_request();

        // Direction reversal mid-ramp.
        vif.voltage_target  = 8'd40;
        vif.voltage_request = 1'b1;
        tick();
        check("rev_dir_down", 32'(vif.ramp_dir_up), 32'd0);
        wait_vout(8'd100);
        vif.voltage_target = 8'd110;
        wait_stable(lat);
        check("rev_vout", 32'(vif.vout_code), 32'd110);
        check("rev_dir_up", 32'(vif.ramp_dir_up), 32'd1);
        drop_request();

        // Set and clear of err_clamped on the same cycle: set wins.
        vif.voltage_target  = 8'd200;
        vif.voltage_request = 1'b1;
        vif.clr_err         = 1'b1;
        tick();
        vif.clr_err = 1'b0;
        check("err_set_wins", 32'(vif.err_clamped), 32'd1);
        drop_request();
        check("err_sticky", 32'(vif.err_clamped), 32'd1);

        // Asynchronous reset away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        rst_n = 1'b1;
        tick();

        // Abort a ramp at 80: code holds, no transaction counted, then settle-only re-request.
        vif.voltage_target  = 8'd40;
        vif.voltage_request = 1'b1;
        tick();
        wait_vout(8'd80);
        drop_request();
        check("abort_active", 32'(vif.ramp_active), 32'd0);
        check("abort_stable", 32'(vif.voltage_stable), 32'd0);
        repeat (6) tick();
        check("abort_hold_vout", 32'(vif.vout_code), 32'd80);
        check("abort_cnt", 32'(vif.transaction_count), 32'd0);
        vif.voltage_target  = 8'd80;
        vif.voltage_request = 1'b1;
        tick();
        wait_stable(lat);
        check("resettle_lat", 32'(lat + 1), 32'd9);
        check("resettle_cnt", 32'(vif.transaction_count), 32'd1);
        drop_request();

        // Reset mid-ramp at 70.
        vif.voltage_target  = 8'd40;
        vif.voltage_request = 1'b1;
        tick();
        wait_vout(8'd70);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midramp_rst");
        vif.voltage_request = 1'b0;
        rst_n = 1'b1;
        tick();
        check("midramp_rst_hold", 32'(vif.vout_code), 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pmu_voltage_sequencer.md
Name: pmu_voltage_sequencer

Overview:
- PMU-side responder for the DVFS voltage handshake.
- Accepts a level-held voltage request plus a target code in mV/10.
- Slews the regulator output code toward the target in fixed steps, waits a settle interval, then asserts voltage_stable until the request is withdrawn.
- Sits between the DVFS controller and the analog regulator trim interface.

Parameters:
- STEP_SIZE, 2, max code change per step (mV/10 units; 2 = 20 mV).
- STEP_CYCLES, 100, clk cycles per ramp step (≥1).
- SETTLE_CYCLES, 200, clk cycles of settle after final step (≥1).
- VMIN_CODE, 40, lowest legal output code (0.40 V).
- VMAX_CODE, 110, highest legal output code (1.10 V).
- RESET_CODE, 100, output code after reset (1.00 V).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- voltage_request  in  1  level request from DVFS; held until stable observed
- voltage_target  in  8  requested voltage, mV/10
- clr_err  in  1  single-cycle clear of err_clamped
- voltage_stable  out  1  output reached target and settled
- vout_code  out  8  regulator trim code, mV/10
- ramp_active  out  1  high in RAMP or SETTLE
- ramp_dir_up  out  1  direction of the current/last ramp (1 = up)
- err_clamped  out  1  sticky: a target outside [VMIN_CODE, VMAX_CODE] was clamped
- transaction_count  out  16  completed transactions (STABLE entries), wraps at 0xFFFF→0

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, vout_code = RESET_CODE, voltage_stable = 0, ramp_active = 0, ramp_dir_up = 0, err_clamped = 0, transaction_count = 0, and all internal counters = 0.
- All outputs are registered.
- eff_target = voltage_target clamped to [VMIN_CODE, VMAX_CODE]. It is computed combinationally and re-evaluated every cycle.
- err_clamped:
  - Sets on any cycle where voltage_request = 1 and voltage_target is out of range.
  - clr_err clears it. When set and clr_err coincide, set wins.
- IDLE:
  - voltage_stable = 0.
  - When voltage_request = 1 and eff_target ≠ vout_code → RAMP. Load step_cnt = 0 and set ramp_dir_up = (eff_target > vout_code).
  - When voltage_request = 1 and eff_target = vout_code → SETTLE directly.
- RAMP:
  - step_cnt increments each cycle.
  - When step_cnt = STEP_CYCLES-1: vout_code moves toward eff_target by min(STEP_SIZE, |eff_target − vout_code|), and step_cnt resets to 0.
  - Once vout_code equals eff_target, the next state is SETTLE with settle_cnt = 0.
  - Arithmetic uses 9-bit signed difference; no overshoot, no wrap.
- SETTLE:
  - settle_cnt counts up. At SETTLE_CYCLES-1 → STABLE.
  - If eff_target ≠ vout_code during SETTLE (target retarget) → RAMP and update ramp_dir_up.
- STABLE:
  - voltage_stable = 1.
  - transaction_count increments once, on entry.
  - If the target changes while the request is still high → RAMP and drop voltage_stable the same edge.
- Request dropped in any state → IDLE next edge:
  - vout_code holds its current value; no snap-back.
  - voltage_stable goes low.
  - An aborted ramp is not counted.
- Retarget mid-RAMP: the new eff_target is used at the next step boundary. A direction reversal is permitted and updates ramp_dir_up.
- voltage_stable is never high in the cycle after a new request is first sampled in IDLE. This guarantees the DVFS side cannot see a stale stable.
- ramp_active = (state ∈ {RAMP, SETTLE}).
- Latency for distance D codes, with request first sampled in IDLE at cycle T:
  - RAMP occupies ceil(D/STEP_SIZE)·STEP_CYCLES cycles.
  - SETTLE occupies SETTLE_CYCLES cycles.
  - voltage_stable is high starting at T+1+ceil(D/STEP_SIZE)·STEP_CYCLES+SETTLE_CYCLES.

Optional Feature:
- Macro PMU_POWER_GOOD_EN.
- When defined:
  - Adds parameter PGOOD_MIN_CODE (default 55) and output power_good (1 bit, reset 0).
  - power_good is registered: 1 when vout_code ≥ PGOOD_MIN_CODE and state ≠ RAMP; otherwise 0.
  - Once power_good is 1, it deasserts on the cycle vout_code first drops below PGOOD_MIN_CODE.
- When undefined: no port, no parameter, no logic; all other behaviour is identical.

Test Plan:
Bench parameters: STEP_SIZE=2, STEP_CYCLES=4, SETTLE_CYCLES=8.
- Reset, request target 60 at T → vout_code decrements 100→60 in 20 steps every 4 cycles; ramp_dir_up = 0; voltage_stable = 1 at T+89; transaction_count = 1.
- From 60, request target 100 → ramp up, ramp_dir_up = 1, stable at T+89. Then drop request → stable = 0 next cycle and vout_code holds 100.
- Request target 20 → err_clamped = 1; vout ramps only to 40 (30 steps), stable at T+129. Pulse clr_err → err_clamped = 0.
- Request target 61 from 60 → single step of 1; stable at T+13.
- Ramp 100→40 and drop request when vout = 80 → IDLE, vout stays 80, transaction_count unchanged. Re-request 80 → SETTLE only; stable at T+9.
- Assert rst_n low mid-RAMP at vout = 70 → vout_code = 100 and all outputs at reset values immediately. With PMU_POWER_GOOD_EN, power_good = 0 after reset and falls when vout crosses 54.
